hp_video_capture: RTL

Captures the HP instrument's monochrome raster video into the frame-buffer BRAM. This block is the write-side counterpart of the VGA output path: the VGA path reads bytes from the same BRAM at the VGA pixel rate, and this block writes them. Video, dot-clock and sync inputs arrive asynchronously to CLK. They are synchronised, edge-detected and windowed, and each visible dot becomes one 8-bit grey byte at a linear address.

---
 rtl/hp_video_capture.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hp_video_capture.sv
// Captures HP monochrome raster video into a linear 8-bit frame buffer.
// Asynchronous HP inputs are synchronised, edge-detected and windowed before each dot is written.
module hp_video_capture #(
  parameter int H_START  = 0,
  parameter int H_ACTIVE = 128,
  parameter int V_START  = 0,
  parameter int V_ACTIVE = 128
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_hp_dot,
  input  logic        i_hp_video,
  input  logic        i_hp_half,
  input  logic        i_hp_hsync,
  input  logic        i_hp_vsync,
  output logic [13:0] o_bram_addr,
  output logic [7:0]  o_bram_din,
  output logic        o_bram_we,
  output logic        o_frame_done
);

  localparam logic [11:0] LP_H_START  = 12'(H_START);
  localparam logic [11:0] LP_H_ACTIVE = 12'(H_ACTIVE);
  localparam logic [11:0] LP_V_START  = 12'(V_START);
  localparam logic [11:0] LP_V_ACTIVE = 12'(V_ACTIVE);
  localparam logic [14:0] LP_H_STRIDE = 15'(H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VSKIP    = 3'd1,
    S_HSKIP    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_LINE_END = 3'd4
  } state_t;

  // With no horizontal offset a new line goes straight to capture.
  localparam state_t LP_LINE_START = (H_START == 0) ? S_CAPTURE : S_HSKIP;

  function automatic logic [7:0] pixel_value(input logic video, input logic half);
    logic [7:0] value;
    if (!video) begin
      value = 8'h00;
    end else if (half) begin
      value = 8'h80;
    end else begin
      value = 8'hFF;
    end
    return value;
  endfunction

  logic [4:0]  w_hp_in;
  logic [4:0]  r_sync1;
  logic [4:0]  r_sync2;
  logic [2:0]  r_sync3;
  logic        r_dot_edge;
  logic        r_hs_edge;
  logic        r_vs_edge;
  logic        r_video;
  logic        r_half;

  state_t      r_state;
  logic [11:0] r_x;
  logic [11:0] r_line_cnt;
  logic [11:0] r_skip_cnt;
  logic [14:0] r_line_base;
  logic [13:0] r_addr;
  logic [7:0]  r_din;
  logic        r_we;
  logic        r_done;

  state_t      w_state_nxt;
  logic [11:0] w_x_nxt;
  logic [11:0] w_line_cnt_nxt;
  logic [11:0] w_skip_nxt;
  logic [14:0] w_line_base_nxt;
  logic [13:0] w_addr_nxt;
  logic [7:0]  w_din_nxt;
  logic        w_we_nxt;
  logic        w_done_nxt;
  logic        w_line_end;
  logic [14:0] w_sum;

  // Bit order: dot, hsync, vsync, video, half.
  assign w_hp_in = {i_hp_half, i_hp_video, i_hp_vsync, i_hp_hsync, i_hp_dot};
  assign w_sum   = r_line_base + {3'b000, r_x};

  // Synchronisers plus registered rising-edge strobes with their matching pixel bits.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1    <= 5'd0;
      r_sync2    <= 5'd0;
      r_sync3    <= 3'd0;
      r_dot_edge <= 1'b0;
      r_hs_edge  <= 1'b0;
      r_vs_edge  <= 1'b0;
      r_video    <= 1'b0;
      r_half     <= 1'b0;
    end else begin
      r_sync1    <= w_hp_in;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2[2:0];
      r_dot_edge <= r_sync2[0] & ~r_sync3[0];
      r_hs_edge  <= r_sync2[1] & ~r_sync3[1];
      r_vs_edge  <= r_sync2[2] & ~r_sync3[2];
      r_video    <= r_sync2[3];
      r_half     <= r_sync2[4];
    end
  end

  // Capture FSM: next state, counters and the write/done strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_line_cnt_nxt  = r_line_cnt;
    w_skip_nxt      = r_skip_cnt;
    w_line_base_nxt = r_line_base;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_we_nxt        = 1'b0;
    w_done_nxt      = 1'b0;
    w_line_end      = 1'b0;

    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else if (r_vs_edge) begin
      // VSYNC outranks everything, including a coincident HSYNC.
      w_state_nxt     = S_VSKIP;
      w_x_nxt         = 12'd0;
      w_line_cnt_nxt  = 12'd0;
      w_skip_nxt      = 12'd0;
      w_line_base_nxt = 15'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_VSKIP: begin
          if (r_hs_edge) begin
            if (r_skip_cnt == LP_V_START) begin
              w_state_nxt = LP_LINE_START;
              w_skip_nxt  = 12'd0;
            end else begin
              w_skip_nxt = r_skip_cnt + 12'd1;
            end
          end else begin
            w_state_nxt = S_VSKIP;
          end
        end
        S_HSKIP: begin
          if (r_hs_edge) begin
            w_line_end = 1'b1;
          end else if (r_dot_edge) begin
            if (r_skip_cnt + 12'd1 == LP_H_START) begin
              w_state_nxt = S_CAPTURE;
              w_skip_nxt  = 12'd0;
            end else begin
              w_skip_nxt = r_skip_cnt + 12'd1;
            end
          end else begin
            w_state_nxt = S_HSKIP;
          end
        end
        S_CAPTURE: begin
          if (r_hs_edge) begin
            w_line_end = 1'b1;
          end else if (r_dot_edge) begin
            if (!w_sum[14]) begin
              w_we_nxt   = 1'b1;
              w_addr_nxt = w_sum[13:0];
              w_din_nxt  = pixel_value(r_video, r_half);
            end else begin
              w_we_nxt = 1'b0;
            end
            w_x_nxt = r_x + 12'd1;
            if (r_x + 12'd1 == LP_H_ACTIVE) begin
              w_state_nxt = S_LINE_END;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end else begin
            w_state_nxt = S_CAPTURE;
          end
        end
        S_LINE_END: begin
          if (r_hs_edge) begin
            w_line_end = 1'b1;
          end else begin
            w_state_nxt = S_LINE_END;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Short lines still advance by a full stride so every line keeps its slot.
    if (w_line_end) begin
      w_line_base_nxt = r_line_base + LP_H_STRIDE;
      w_line_cnt_nxt  = r_line_cnt + 12'd1;
      w_x_nxt         = 12'd0;
      w_skip_nxt      = 12'd0;
      if (r_line_cnt + 12'd1 == LP_V_ACTIVE) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = LP_LINE_START;
      end
    end else begin
      w_done_nxt = w_done_nxt;
    end
  end

  // FSM state, counters and registered BRAM/done outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= 12'd0;
      r_line_cnt  <= 12'd0;
      r_skip_cnt  <= 12'd0;
      r_line_base <= 15'd0;
      r_addr      <= 14'd0;
      r_din       <= 8'd0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_line_cnt  <= w_line_cnt_nxt;
      r_skip_cnt  <= w_skip_nxt;
      r_line_base <= w_line_base_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_we        <= w_we_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_bram_addr  = r_addr;
  assign o_bram_din   = r_din;
  assign o_bram_we    = r_we;
  assign o_frame_done = r_done;

endmodule
